// File: rtl/pc_ctrl_pkg.sv
// Shared types for the PC write-path sequencer:
// request kinds, causes, PC-source codes, states.
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    K_SEQ    = 3'd0,
    K_BRANCH = 3'd1,
    K_JUMP   = 3'd2,
    K_ERET   = 3'd3,
    K_EXC    = 3'd4
  } kind_e;

  typedef enum logic [1:0] {
    C_INVOP = 2'd0,
    C_OVF   = 2'd1,
    C_DIVZ  = 2'd2
  } cause_e;

  typedef enum logic [1:0] {
    PCS_EXC = 2'd0,
    PCS_EPC = 2'd1,
    PCS_ALU = 2'd2,
    PCS_SL2 = 2'd3
  } pcsrc_e;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_UPDATE   = 3'd1,
    S_EXC_EPC  = 3'd2,
    S_EXC_MEM  = 3'd3,
    S_EXC_LOAD = 3'd4,
    S_EXC_JUMP = 3'd5
  } state_e;

  localparam int VEC_BASE_DEF = 253;

  // Undefined kind codes fold into the exception path.
  function automatic kind_e norm_kind(
    input logic [2:0] k
  );
    return (k > 3'd4) ? K_EXC : kind_e'(k);
  endfunction

  function automatic cause_e norm_cause(
    input logic [1:0] c
  );
    return (c == 2'd3) ? C_INVOP : cause_e'(c);
  endfunction

  function automatic pcsrc_e kind_src(
    input kind_e k
  );
    pcsrc_e s;
    s = PCS_ALU;
    if (k == K_JUMP) s = PCS_SL2;
    if (k == K_ERET) s = PCS_EPC;
    return s;
  endfunction

endpackage

// File: rtl/pc_update_ctrl_if.sv
// Request/control bundle between the main control
// unit and the PC write-path sequencer.
interface pc_update_ctrl_if;
  import pc_ctrl_pkg::*;

  logic        req_valid;
  logic [2:0]  req_kind;
  logic        cond;
  logic [1:0]  exc_cause;
  logic        busy;
  logic        done;
  logic [1:0]  pc_source;
  logic        pc_write;
  logic        epc_write;
  logic        mem_read;
  logic [31:0] vec_addr;
  logic        vec_load;

  modport master (
    output req_valid, req_kind, cond, exc_cause,
    input  busy, done, pc_source, pc_write,
    input  epc_write, mem_read, vec_addr, vec_load
  );

  modport slave (
    input  req_valid, req_kind, cond, exc_cause,
    output busy, done, pc_source, pc_write,
    output epc_write, mem_read, vec_addr, vec_load
  );

endinterface

// File: rtl/wait_counter.sv
// Loadable down-counter with a zero flag; it
// saturates at zero.
module wait_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  assign o_zero = (r_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && !o_zero) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

endmodule

// File: rtl/pc_update_ctrl.sv
// PC write-path sequencer: single-cycle PC updates
// plus the multi-cycle exception vector sequence.
module pc_update_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter int VEC_BASE = VEC_BASE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  pc_update_ctrl_if.slave   bus
);

  localparam logic [2:0]  LOAD_VAL = 3'(MEM_WAIT - 1);
  localparam logic [31:0] VB       = 32'(VEC_BASE);

  state_e      r_state, w_next;
  kind_e       r_kind, w_kind;
  logic        r_cond, w_cond;
  cause_e      r_cause;
  logic        w_accept, w_zero;

  logic        r_busy, w_busy;
  logic        r_done, w_done;
  pcsrc_e      r_src, w_src;
  logic        r_pcw, w_pcw;
  logic        r_epcw, w_epcw;
  logic        r_mrd, w_mrd;
  logic [31:0] r_vaddr, w_vaddr;
  logic        r_vld, w_vld;

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;

  // Outputs for the accept cycle must see the
  // incoming request, not the stale latch.
  assign w_kind = w_accept ? norm_kind(bus.req_kind)
                           : r_kind;
  assign w_cond = w_accept ? bus.cond : r_cond;

  wait_counter #(.W(3)) u_wait (
    .clk    (clk),
    .reset  (reset),
    .i_load (r_state == S_EXC_EPC),
    .i_val  (LOAD_VAL),
    .i_dec  (r_state == S_EXC_MEM),
    .o_zero (w_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_kind  <= K_SEQ;
      r_cond  <= 1'b0;
      r_cause <= C_INVOP;
    end else if (w_accept) begin
      r_kind  <= w_kind;
      r_cond  <= bus.cond;
      r_cause <= norm_cause(bus.exc_cause);
    end
  end

  always_comb begin
    w_next  = r_state;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    w_pcw   = 1'b0;
    w_epcw  = 1'b0;
    w_mrd   = 1'b0;
    w_vld   = 1'b0;
    w_src   = r_src;
    w_vaddr = r_vaddr;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (w_kind == K_EXC) ? S_EXC_EPC
                                     : S_UPDATE;
        end
      end
      S_UPDATE:   w_next = S_IDLE;
      S_EXC_EPC:  w_next = S_EXC_MEM;
      S_EXC_MEM:  if (w_zero) w_next = S_EXC_LOAD;
      S_EXC_LOAD: w_next = S_EXC_JUMP;
      S_EXC_JUMP: w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase

    // Output registers take the value of the
    // state being entered.
    unique case (1'b1)
      (w_next == S_UPDATE): begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_pcw  = (w_kind == K_BRANCH) ? w_cond : 1'b1;
        if (w_pcw) w_src = kind_src(w_kind);
      end
      (w_next == S_EXC_EPC): begin
        w_busy = 1'b1;
        w_epcw = 1'b1;
      end
      (w_next == S_EXC_MEM): begin
        w_busy  = 1'b1;
        w_mrd   = 1'b1;
        w_vaddr = VB + {30'd0, r_cause};
      end
      (w_next == S_EXC_LOAD): begin
        w_busy  = 1'b1;
        w_vld   = 1'b1;
        w_vaddr = VB + {30'd0, r_cause};
      end
      (w_next == S_EXC_JUMP): begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_pcw  = 1'b1;
        w_src  = PCS_EXC;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_src   <= PCS_EXC;
      r_pcw   <= 1'b0;
      r_epcw  <= 1'b0;
      r_mrd   <= 1'b0;
      r_vaddr <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_src   <= w_src;
      r_pcw   <= w_pcw;
      r_epcw  <= w_epcw;
      r_mrd   <= w_mrd;
      r_vaddr <= w_vaddr;
      r_vld   <= w_vld;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pc_source = r_src;
  assign bus.pc_write  = r_pcw;
  assign bus.epc_write = r_epcw;
  assign bus.mem_read  = r_mrd;
  assign bus.vec_addr  = r_vaddr;
  assign bus.vec_load  = r_vld;

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Bench for pc_update_ctrl: per-cycle output traces
// from a request-level model, directed + random.
module tb_pc_update_ctrl;

  localparam int MW = 2;
  localparam int VB = 253;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_update_ctrl_if bus();

  pc_update_ctrl #(
    .MEM_WAIT (MW),
    .VEC_BASE (VB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        pc_write;
    logic        epc_write;
    logic        mem_read;
    logic        vec_load;
    logic [1:0]  pc_source;
    logic [31:0] vec_addr;
  } obs_t;

  obs_t        exp_q[$];
  obs_t        got;
  int          vectors = 0;
  int          errors  = 0;
  logic [1:0]  m_src   = 2'd0;
  logic [31:0] m_vaddr = 32'd0;

  function automatic obs_t sample();
    obs_t o;
    o.busy      = bus.busy;
    o.done      = bus.done;
    o.pc_write  = bus.pc_write;
    o.epc_write = bus.epc_write;
    o.mem_read  = bus.mem_read;
    o.vec_load  = bus.vec_load;
    o.pc_source = bus.pc_source;
    o.vec_addr  = bus.vec_addr;
    return o;
  endfunction

  function automatic obs_t mk(
    input logic b, d, pw, ew, mr, vl
  );
    obs_t o;
    o = {b, d, pw, ew, mr, vl, m_src, m_vaddr};
    return o;
  endfunction

  // Expected cycle-by-cycle trace of one request,
  // ending with the idle cycle that follows it.
  task automatic model_req(
    input logic [2:0] k,
    input logic       c,
    input logic [1:0] cz
  );
    int   cause;
    logic take;
    exp_q.delete();
    cause = (cz == 2'd3) ? 0 : int'(cz);
    if (k < 3'd4) begin
      take = (k == 3'd1) ? c : 1'b1;
      if (take) begin
        case (k)
          3'd2:    m_src = 2'b11;
          3'd3:    m_src = 2'b01;
          default: m_src = 2'b10;
        endcase
      end
      exp_q.push_back(mk(1, 1, take, 0, 0, 0));
    end else begin
      exp_q.push_back(mk(1, 0, 0, 1, 0, 0));
      m_vaddr = 32'(VB + cause);
      for (int i = 0; i < MW; i++)
        exp_q.push_back(mk(1, 0, 0, 0, 1, 0));
      exp_q.push_back(mk(1, 0, 0, 0, 0, 1));
      m_src = 2'b00;
      exp_q.push_back(mk(1, 1, 1, 0, 0, 0));
    end
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
  endtask

  task automatic send(
    input logic [2:0] k,
    input logic       c,
    input logic [1:0] cz
  );
    bus.req_valid = 1'b1;
    bus.req_kind  = k;
    bus.cond      = c;
    bus.exc_cause = cz;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b1;
    bus.req_kind  = 3'd0;
    bus.cond      = 1'b0;
    bus.exc_cause = 2'd0;
    repeat (2) @(negedge clk);
    got = sample();
    vectors++;
    if (got !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=%h",
               got, obs_t'(0));
    end
    bus.req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    got = sample();
    vectors++;
    if (got !== obs_t'(0)) begin
      errors++;
      $display("FAIL reset_rel got=%h exp=%h",
               got, obs_t'(0));
    end
  endtask

  task automatic test_seq();
    send(3'd0, 1'b0, 2'd0);
    model_req(3'd0, 1'b0, 2'd0);
    foreach (exp_q[i]) begin
      if (i > 0) @(negedge clk);
      got = sample();
      vectors++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("FAIL seq c%0d got=%h exp=%h",
                 i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_branch_jump_eret();
    logic [2:0] ks[4] = '{3'd1, 3'd1, 3'd2, 3'd3};
    logic       cs[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int t = 0; t < 4; t++) begin
      send(ks[t], cs[t], 2'd0);
      model_req(ks[t], cs[t], 2'd0);
      foreach (exp_q[i]) begin
        if (i > 0) @(negedge clk);
        got = sample();
        vectors++;
        if (got !== exp_q[i]) begin
          errors++;
          $display("FAIL kind%0d c%0d got=%h exp=%h",
                   ks[t], i, got, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_exc();
    logic [2:0] ks[3] = '{3'd4, 3'd4, 3'd7};
    logic [1:0] cz[3] = '{2'd1, 2'd3, 2'd2};
    for (int t = 0; t < 3; t++) begin
      send(ks[t], 1'b0, cz[t]);
      model_req(ks[t], 1'b0, cz[t]);
      foreach (exp_q[i]) begin
        if (i > 0) @(negedge clk);
        got = sample();
        vectors++;
        if (got !== exp_q[i]) begin
          errors++;
          $display("FAIL exc%0d c%0d got=%h exp=%h",
                   t, i, got, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_busy_ignore();
    send(3'd4, 1'b0, 2'd2);
    model_req(3'd4, 1'b0, 2'd2);
    bus.req_valid = 1'b1;
    bus.req_kind  = 3'd2;
    foreach (exp_q[i]) begin
      if (i > 0) @(negedge clk);
      got = sample();
      vectors++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("FAIL busy_exc c%0d got=%h exp=%h",
                 i, got, exp_q[i]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    model_req(3'd2, 1'b0, 2'd0);
    foreach (exp_q[i]) begin
      if (i > 0) @(negedge clk);
      got = sample();
      vectors++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("FAIL busy_jmp c%0d got=%h exp=%h",
                 i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    send(3'd4, 1'b0, 2'd1);
    model_req(3'd4, 1'b0, 2'd1);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      got = sample();
      vectors++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("FAIL pre_rst c%0d got=%h exp=%h",
                 i, got, exp_q[i]);
      end
    end
    #2 reset = 1'b1;
    #1 got = sample();
    vectors++;
    if (got !== obs_t'(0)) begin
      errors++;
      $display("FAIL async_rst got=%h exp=%h",
               got, obs_t'(0));
    end
    m_src   = 2'd0;
    m_vaddr = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) reset = 1'b0;
      got = sample();
      vectors++;
      if (got !== obs_t'(0)) begin
        errors++;
        $display("FAIL post_rst c%0d got=%h exp=%h",
                 i, got, obs_t'(0));
      end
    end
    send(3'd0, 1'b0, 2'd0);
    model_req(3'd0, 1'b0, 2'd0);
    foreach (exp_q[i]) begin
      if (i > 0) @(negedge clk);
      got = sample();
      vectors++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("FAIL rst_seq c%0d got=%h exp=%h",
                 i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] k;
    logic       c;
    logic [1:0] cz;
    for (int n = 0; n < 60; n++) begin
      k  = 3'($urandom_range(0, 7));
      c  = 1'($urandom_range(0, 1));
      cz = 2'($urandom_range(0, 3));
      send(k, c, cz);
      model_req(k, c, cz);
      foreach (exp_q[i]) begin
        if (i > 0) @(negedge clk);
        got = sample();
        vectors++;
        if (got !== exp_q[i]) begin
          errors++;
          $display("FAIL rnd%0d k%0d c%0d got=%h exp=%h",
                   n, k, i, got, exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_seq();
    test_branch_jump_eret();
    test_exc();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
